// File: rtl/position_read_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : position_read_pkg
//  Description : Shared types and constants for the multi-channel
//                position-read scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package position_read_pkg;

    // Per-channel sequencing state.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_FLUSH = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } chan_state_e;

    // Default width of each per-channel batch counter.
    localparam int c_CNT_W_DEFAULT = 16;

    // Saturation value of a default-width batch counter.
    localparam logic [c_CNT_W_DEFAULT-1:0] c_BATCH_CNT_SAT = '1;

endpackage : position_read_pkg
`default_nettype wire

// File: rtl/position_read_channel.sv
`default_nettype none
// ============================================================================
//  Module      : position_read_channel
//  Description : One position-read pipe sequencer: prime, flush, batch
//                dispatch with pending re-dispatch, saturating batch count,
//                sticky done.
//  Revision    : 1.0 - initial release
// ============================================================================
module position_read_channel
    import position_read_pkg::*;
#(
    parameter int CNT_W       = c_CNT_W_DEFAULT,
    parameter int PRIME_DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ready,
    input  logic             finished_batch,
    input  logic             finished_all,
    input  logic             in_flight,
    output logic             dispatch,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] batch_count
);

    localparam int              c_PC_W    = (PRIME_DEPTH < 2) ? 1 : $clog2(PRIME_DEPTH + 1);
    localparam logic [c_PC_W-1:0] c_PC_LAST = c_PC_W'(PRIME_DEPTH);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;

    chan_state_e        state_q, state_d;
    logic [c_PC_W-1:0]  prime_cnt_q, prime_cnt_d;
    logic               pending_q, pending_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dispatch_q, dispatch_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_inc;

    // Counter increment that holds at the top value instead of wrapping.
    assign cnt_inc = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            prime_cnt_q <= '0;
            pending_q   <= 1'b0;
            cnt_q       <= '0;
            dispatch_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            dispatch_q  <= dispatch_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and next-output decode; ready low overrides every state.
    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        pending_d   = pending_q;
        cnt_d       = cnt_q;
        dispatch_d  = 1'b0;
        done_d      = 1'b0;

        if (!ready) begin
            state_d     = ST_IDLE;
            prime_cnt_d = '0;
            pending_d   = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_PRIME;
                    dispatch_d  = 1'b1;
                    prime_cnt_d = c_PC_W'(1);
                end
                ST_PRIME: begin
                    dispatch_d = 1'b1;
                    if (prime_cnt_q == c_PC_LAST) begin
                        state_d = ST_FLUSH;
                    end else begin
                        prime_cnt_d = prime_cnt_q + c_PC_W'(1);
                    end
                end
                ST_FLUSH: begin
                    // The FLUSH->RUN dispatch is a prime request, not a batch.
                    dispatch_d = 1'b1;
                    if (!in_flight) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (finished_batch && finished_all) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        pending_d = 1'b0;
                    end else if (finished_batch && !in_flight) begin
                        // This dispatch also serves any older pending request.
                        dispatch_d = 1'b1;
                        cnt_d      = cnt_inc;
                        pending_d  = 1'b0;
                    end else if (finished_batch && in_flight) begin
                        pending_d = 1'b1;
                    end else if (pending_q && !in_flight) begin
                        dispatch_d = 1'b1;
                        pending_d  = 1'b0;
                        cnt_d      = cnt_inc;
                    end
                end
                ST_DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_PRIME) || (state_d == ST_FLUSH) || (state_d == ST_RUN);
    end

    assign dispatch    = dispatch_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign batch_count = cnt_q;

endmodule : position_read_channel
`default_nettype wire

// File: rtl/position_read_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : position_read_scheduler
//  Description : N_CH independent position-read channel sequencers plus an
//                aggregate registered all_done.
//  Revision    : 1.0 - initial release
// ============================================================================
module position_read_scheduler
    import position_read_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = c_CNT_W_DEFAULT,
    parameter int PRIME_DEPTH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       ready,
    input  logic [N_CH-1:0]       finished_batch,
    input  logic [N_CH-1:0]       finished_all,
    input  logic [N_CH-1:0]       in_flight,
    output logic [N_CH-1:0]       dispatch,
    output logic [N_CH-1:0]       done,
    output logic [N_CH-1:0]       busy,
    output logic [N_CH*CNT_W-1:0] batch_count,
    output logic                  all_done
);

    logic all_done_q;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            position_read_channel #(
                .CNT_W       (CNT_W),
                .PRIME_DEPTH (PRIME_DEPTH)
            ) u_channel (
                .clk            (clk),
                .reset          (reset),
                .ready          (ready[gi]),
                .finished_batch (finished_batch[gi]),
                .finished_all   (finished_all[gi]),
                .in_flight      (in_flight[gi]),
                .dispatch       (dispatch[gi]),
                .done           (done[gi]),
                .busy           (busy[gi]),
                .batch_count    (batch_count[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

    // Aggregate completion, sampled from the registered done vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            all_done_q <= 1'b0;
        end else begin
            all_done_q <= &done;
        end
    end

    assign all_done = all_done_q;

endmodule : position_read_scheduler
`default_nettype wire
